// File: rtl/mod_mult_pkg.sv
// Shared types for the modular-multiply sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mod_mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DBL,
        RED1,
        ADD,
        RED2,
        DONE
    } mm_state_t;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/mod_mult_seq.sv
// Sequencer for R = (A*B) mod M, MSB-first interleaved, one shared add/sub ALU op per cycle.
// Latency: 2N + 2*popcount(A) + 1 cycles (4N+1 with MOD_MULT_CONST_TIME_EN), 1 cycle on bad modulus.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or in the done cycle.
module mod_mult_seq
    import mod_mult_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [N-1:0] m_in,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_func,
    input  logic [N-1:0] alu_result,
    input  logic         alu_c,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         err
);

    // Bit index width; N is expected to be a power of two so the index covers 0..N-1 exactly.
    localparam int IW = $clog2(N);

`ifdef MOD_MULT_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    mm_state_t      state;
    logic [N-1:0]   r;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [N-1:0]   m_q;
    logic [IW-1:0]  idx;

    // Conditional-subtract result: keep R-M only when it did not borrow.
    logic [N-1:0]   red_val;
    logic           last_bit;
    logic           bit_set;

    assign red_val  = alu_c ? r : alu_result;
    assign last_bit = (idx == '0);
    assign bit_set  = a_q[idx];

    // ALU operand selection is a pure function of the current state and registers.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_func = ALU_ADD;
        case (state)
            DBL: begin
                alu_a    = r;
                alu_b    = r;
                alu_func = ALU_ADD;
            end
            RED1, RED2: begin
                alu_a    = r;
                alu_b    = m_q;
                alu_func = ALU_SUB;
            end
            ADD: begin
                alu_a    = r;
`ifdef MOD_MULT_CONST_TIME_EN
                // Dummy add of zero keeps the op sequence independent of A.
                alu_b    = bit_set ? b_q : '0;
`else
                alu_b    = b_q;
`endif
                alu_func = ALU_ADD;
            end
            default: begin
                alu_a    = '0;
                alu_b    = '0;
                alu_func = ALU_ADD;
            end
        endcase
    end

    // Control FSM with operand, accumulator and bit-counter registers; busy/done/result/err registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            r      <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= a_in;
                        b_q <= b_in;
                        m_q <= m_in;
                        r   <= '0;
                        idx <= IW'(N - 1);
                        // M must be non-zero and below 2^(N-1) so doubling R never overflows.
                        if (m_in == '0 || m_in[N-1]) begin
                            state  <= DONE;
                            err    <= 1'b1;
                            result <= '0;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            state <= DBL;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                DBL: begin
                    r     <= alu_result;
                    state <= RED1;
                end
                RED1: begin
                    r <= red_val;
                    if (CONST_TIME || bit_set) begin
                        state <= ADD;
                    end else if (last_bit) begin
                        // Result is published together with the done pulse.
                        state  <= DONE;
                        result <= red_val;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        idx   <= idx - IW'(1);
                        state <= DBL;
                    end
                end
                ADD: begin
                    r     <= alu_result;
                    state <= RED2;
                end
                RED2: begin
                    r <= red_val;
                    if (last_bit) begin
                        state  <= DONE;
                        result <= red_val;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        idx   <= idx - IW'(1);
                        state <= DBL;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mult_seq.sv
// Self-checking bench for mod_mult_seq (N=8) paired with a behavioural add/sub ALU.
// Latency: reference latency computed from A's bit count (or fixed with MOD_MULT_CONST_TIME_EN).
// Backpressure: exercises start while busy, start held through done, and mid-run reset.
module tb_mod_mult_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a_in, b_in, m_in;
    logic [N-1:0] alu_a, alu_b;
    logic         alu_func;
    logic [N-1:0] alu_result;
    logic         alu_c;
    logic         busy, done, err;
    logic [N-1:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Add/sub ALU: carry-out on add, borrow (a<b) on subtract.
    logic [N:0] alu_wide;
    assign alu_wide   = alu_func ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
    assign alu_result = alu_wide[N-1:0];
    assign alu_c      = alu_wide[N];

    mod_mult_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .m_in       (m_in),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .err        (err)
    );

    // Reference latency from accept edge to done cycle.
    function automatic int ref_lat(input logic [N-1:0] a);
`ifdef MOD_MULT_CONST_TIME_EN
        return 4 * N + 1;
`else
        return 2 * N + 2 * $countones(a) + 1;
`endif
    endfunction

    function automatic logic [N-1:0] ref_mod(input int a, input int b, input int m);
        return N'((a * b) % m);
    endfunction

    // Launch one operation and wait for done; lat counts cycles after the accept edge (1 = next cycle).
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                          output logic [N-1:0] res, output logic e, output int lat,
                          output int busy_cyc, output logic busy_at_done, output bit to);
        @(negedge clk);
        a_in = a; b_in = b; m_in = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cyc = 0; to = 1'b1; res = '0; e = 1'b0; busy_at_done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done === 1'b1) begin
                res = result; e = err; busy_at_done = busy; to = 1'b0;
                break;
            end
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; m_in = '0;
        #2;
        checks++;
        if ({busy, done, err, result, alu_a, alu_b, alu_func} !== '0) begin
            errors++;
            $display("FAIL reset_values: got busy=%b done=%b err=%b result=%0d alu_a=%0d alu_b=%0d func=%b, want all 0",
                     busy, done, err, result, alu_a, alu_b, alu_func);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        logic [N-1:0] res; logic e, bd; int lat, bc; bit to;
        run_op(8'd5, 8'd7, 8'd11, res, e, lat, bc, bd, to);
        checks++;
        if (to || res !== 8'd2 || e !== 1'b0) begin
            errors++;
            $display("FAIL basic_5x7m11: got result=%0d err=%b timeout=%0d, want result=2 err=0", res, e, to);
        end
        checks++;
        if (lat !== ref_lat(8'd5)) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want %0d", lat, ref_lat(8'd5));
        end
        checks++;
        if (bd !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_in_done: got busy=%b, want 0", bd);
        end
    endtask

    task automatic test_zero_a;
        logic [N-1:0] res; logic e, bd; int lat, bc; bit to;
        run_op(8'd0, 8'd9, 8'd13, res, e, lat, bc, bd, to);
        checks++;
        if (to || res !== 8'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL zero_a_result: got result=%0d err=%b timeout=%0d, want 0 0", res, e, to);
        end
        checks++;
        if (lat !== ref_lat(8'd0)) begin
            errors++;
            $display("FAIL zero_a_latency: got %0d, want %0d", lat, ref_lat(8'd0));
        end
        checks++;
        if (bc !== lat - 1) begin
            errors++;
            $display("FAIL zero_a_busy: busy high %0d cycles, want %0d", bc, lat - 1);
        end
    endtask

    task automatic test_mod_err;
        logic [N-1:0] res; logic e, bd; int lat, bc; bit to;
        logic [N-1:0] mods [2];
        mods[0] = 8'h80; mods[1] = 8'h00;
        for (int j = 0; j < 2; j++) begin
            run_op(8'd3, 8'd4, mods[j], res, e, lat, bc, bd, to);
            checks++;
            if (to || lat !== 1 || e !== 1'b1 || res !== 8'd0) begin
                errors++;
                $display("FAIL mod_err_m%0h: got lat=%0d err=%b result=%0d timeout=%0d, want lat=1 err=1 result=0",
                         mods[j], lat, e, res, to);
            end
            checks++;
            if (bc !== 0 || alu_a !== '0 || alu_b !== '0 || alu_func !== 1'b0) begin
                errors++;
                $display("FAIL mod_err_no_alu_m%0h: got busy_cycles=%0d alu_a=%0d alu_b=%0d func=%b, want 0",
                         mods[j], bc, alu_a, alu_b, alu_func);
            end
        end
    endtask

    task automatic test_restart_ignored;
        int lat, ndone, first_lat;
        logic [N-1:0] first_res;
        @(negedge clk);
        a_in = 8'd10; b_in = 8'd10; m_in = 8'd97; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; ndone = 0; first_lat = -1; first_res = '0;
        for (int k = 0; k < 80; k++) begin
            if (lat == 5) begin
                start = 1'b1; a_in = 8'd1; b_in = 8'd2; m_in = 8'd5;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                if (first_lat < 0) begin first_lat = lat; first_res = result; end
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1 || first_res !== 8'd3) begin
            errors++;
            $display("FAIL restart_ignored: got %0d done pulses result=%0d, want 1 pulse result=3", ndone, first_res);
        end
        checks++;
        if (first_lat !== ref_lat(8'd10)) begin
            errors++;
            $display("FAIL restart_latency: got %0d, want %0d", first_lat, ref_lat(8'd10));
        end
    endtask

    task automatic test_reset_abort;
        logic [N-1:0] res; logic e, bd; int lat, bc, nd; bit to;
        @(negedge clk);
        a_in = 8'd10; b_in = 8'd10; m_in = 8'd97; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 8; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, result, alu_a, alu_b, alu_func} !== '0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b done=%b err=%b result=%0d alu_a=%0d alu_b=%0d func=%b, want all 0",
                     busy, done, err, result, alu_a, alu_b, alu_func);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d busy/done cycles after abort, want 0", nd);
        end
        run_op(8'd3, 8'd4, 8'd5, res, e, lat, bc, bd, to);
        checks++;
        if (to || res !== 8'd2 || e !== 1'b0 || lat !== ref_lat(8'd3)) begin
            errors++;
            $display("FAIL abort_rerun: got result=%0d err=%b lat=%0d timeout=%0d, want 2 0 %0d",
                     res, e, lat, to, ref_lat(8'd3));
        end
    endtask

    task automatic test_back_to_back;
        int gap;
        logic [N-1:0] r1, r2;
        bit to;
        // start stays high: ignored in the done cycle, accepted in the following idle cycle.
        @(negedge clk);
        a_in = 8'd6; b_in = 8'd9; m_in = 8'd23; start = 1'b1;
        @(negedge clk);
        a_in = 8'd7; b_in = 8'd8; m_in = 8'd29;
        to = 1'b1; r1 = '0;
        for (int k = 0; k < 200; k++) begin
            if (done === 1'b1) begin to = 1'b0; r1 = result; break; end
            @(negedge clk);
        end
        gap = 0; r2 = '0;
        if (!to) begin
            to = 1'b1;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                gap++;
                if (done === 1'b1) begin to = 1'b0; r2 = result; break; end
            end
        end
        start = 1'b0;
        checks++;
        if (to || r1 !== ref_mod(6, 9, 23) || r2 !== ref_mod(7, 8, 29)) begin
            errors++;
            $display("FAIL back_to_back_results: got %0d %0d timeout=%0d, want %0d %0d",
                     r1, r2, to, ref_mod(6, 9, 23), ref_mod(7, 8, 29));
        end
        checks++;
        if (gap !== ref_lat(8'd7) + 1) begin
            errors++;
            $display("FAIL back_to_back_gap: got %0d, want %0d", gap, ref_lat(8'd7) + 1);
        end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_random;
        logic [N-1:0] res; logic e, bd; int lat, bc; bit to;
        int m, a, b, bad_res, bad_lat;
        bad_res = 0; bad_lat = 0;
        for (int n = 0; n < 1000; n++) begin
            m = $urandom_range(127, 1);
            a = $urandom_range(m - 1, 0);
            b = $urandom_range(m - 1, 0);
            run_op(N'(a), N'(b), N'(m), res, e, lat, bc, bd, to);
            checks++;
            if (to || res !== ref_mod(a, b, m) || e !== 1'b0) begin
                errors++;
                bad_res++;
                if (bad_res <= 5)
                    $display("FAIL random_result: %0d*%0d mod %0d got %0d err=%b timeout=%0d, want %0d",
                             a, b, m, res, e, to, ref_mod(a, b, m));
            end
            checks++;
            if (lat !== ref_lat(N'(a))) begin
                errors++;
                bad_lat++;
                if (bad_lat <= 5)
                    $display("FAIL random_latency: A=%0d got %0d, want %0d", a, lat, ref_lat(N'(a)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_a();
        test_mod_err();
        test_restart_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
